// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter
//   Schedules SDRAM burst writes (camera FIFO -> SDRAM) and burst reads
//   (SDRAM -> VGA FIFO) from the FIFO fill levels. When both directions are
//   eligible at the same time, they take turns. Each burst gets a start word
//   address and a bank. Addresses wrap at the end of each frame. With
//   PINGPONG=1, consecutive write frames alternate between banks 0 and 1, and
//   the reader follows the most recently completed write frame.
//
// Ports
//   S_CLK         system clock, rising edge
//   RST           synchronous reset, active-high
//   sdram_ready   SDRAM initialisation complete; no grants while low
//   w_fifo_usedw  write-FIFO fill level
//   r_fifo_usedw  read-FIFO fill level
//   write_ack     one-cycle pulse: write burst finished
//   read_ack      one-cycle pulse: read burst finished
//   write_en      write burst request, held until write_ack
//   read_en       read burst request, held until read_ack
//   addr          start word address of the current burst
//   bank          bank of the current burst
//   frame_done_w  one-cycle pulse: last write burst of a frame acknowledged
//   frame_done_r  one-cycle pulse: last read burst of a frame acknowledged
module sdram_burst_arbiter #(
  parameter int USEDW_W     = 9,
  parameter int ADDR_W      = 20,
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200,
  parameter int WR_THRESH   = 256,
  parameter int RD_THRESH   = 256,
  parameter int PINGPONG    = 1
) (
  input  logic               S_CLK,
  input  logic               RST,
  input  logic               sdram_ready,
  input  logic [USEDW_W-1:0] w_fifo_usedw,
  input  logic [USEDW_W-1:0] r_fifo_usedw,
  input  logic               write_ack,
  input  logic               read_ack,
  output logic               write_en,
  output logic               read_en,
  output logic [ADDR_W-1:0]  addr,
  output logic [1:0]         bank,
  output logic               frame_done_w,
  output logic               frame_done_r
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  // The frame-wrap compare uses one extra bit, so a frame that fills the
  // whole address space does not overflow the compare.
  localparam logic [ADDR_W:0]   FRAME_EXT = (ADDR_W+1)'(FRAME_WORDS);
  localparam logic [ADDR_W:0]   BURST_EXT = (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BURST_STP = ADDR_W'(BURST_LEN);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_addr_reg, rd_addr_reg;
  logic [1:0]        wr_bank_reg, rd_bank_reg, done_bank_reg;
  logic              last_grant_wr_reg;  // 1: the most recent grant was a write
  logic              rd_valid_reg;       // at least one full frame has been written
  logic              wr_ok, rd_ok, grant_wr, grant_rd;
  logic              wr_wrap, rd_wrap;

  assign wr_ok   = 32'(w_fifo_usedw) >= WR_THRESH;
  assign rd_ok   = rd_valid_reg && (32'(r_fifo_usedw) < RD_THRESH);
  assign wr_wrap = ({1'b0, wr_addr_reg} + BURST_EXT) == FRAME_EXT;
  assign rd_wrap = ({1'b0, rd_addr_reg} + BURST_EXT) == FRAME_EXT;

  // State register
  always_ff @(posedge S_CLK) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. The FIFO levels are only examined in IDLE.
  always_comb begin
    state_next = state_reg;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sdram_ready) begin
          // When both directions are eligible, the one not served last wins.
          grant_wr = wr_ok && (!rd_ok || !last_grant_wr_reg);
          grant_rd = rd_ok && !grant_wr;
          if (grant_wr)      state_next = WRITE;
          else if (grant_rd) state_next = READ;
        end
      end
      WRITE:   if (write_ack) state_next = IDLE;
      READ:    if (read_ack)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: each request is a level held for the whole burst state.
  always_comb begin
    write_en = (state_reg == WRITE);
    read_en  = (state_reg == READ);
  end

  // Burst address/bank bookkeeping. Only the ack that matches the current
  // state is acted on; stray acks fall through untouched.
  always_ff @(posedge S_CLK) begin
    if (RST) begin
      addr              <= '0;
      bank              <= 2'd0;
      frame_done_w      <= 1'b0;
      frame_done_r      <= 1'b0;
      wr_addr_reg       <= '0;
      rd_addr_reg       <= '0;
      wr_bank_reg       <= 2'd0;
      rd_bank_reg       <= 2'd0;
      done_bank_reg     <= 2'd0;
      last_grant_wr_reg <= 1'b0;
      rd_valid_reg      <= 1'b0;
    end else begin
      frame_done_w <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_wr) begin
            addr              <= wr_addr_reg;
            bank              <= wr_bank_reg;
            last_grant_wr_reg <= 1'b1;
          end else if (grant_rd) begin
            // A new read frame locks onto the most recently completed write frame.
            if (rd_addr_reg == '0) begin
              rd_bank_reg <= done_bank_reg;
              bank        <= done_bank_reg;
            end else begin
              bank        <= rd_bank_reg;
            end
            addr              <= rd_addr_reg;
            last_grant_wr_reg <= 1'b0;
          end
        end
        WRITE: begin
          if (write_ack) begin
            if (wr_wrap) begin
              wr_addr_reg   <= '0;
              frame_done_w  <= 1'b1;
              done_bank_reg <= wr_bank_reg;
              wr_bank_reg   <= (PINGPONG != 0) ? {1'b0, ~wr_bank_reg[0]} : 2'd0;
              rd_valid_reg  <= 1'b1;
            end else begin
              wr_addr_reg   <= wr_addr_reg + BURST_STP;
            end
          end
        end
        READ: begin
          if (read_ack) begin
            if (rd_wrap) begin
              rd_addr_reg  <= '0;
              frame_done_r <= 1'b1;
            end else begin
              rd_addr_reg  <= rd_addr_reg + BURST_STP;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
